// File: rtl/dat_mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the 256x8 data memory.
// The arbiter takes the slave modport; requesters and memory take the master modport.
interface dat_mem_arb_if;
  logic       p0_req;
  logic       p0_we;
  logic [7:0] p0_addr;
  logic [7:0] p0_wdata;
  logic       p0_gnt;
  logic       p0_rvalid;
  logic [7:0] p0_rdata;

  logic       p1_req;
  logic       p1_we;
  logic       p1_lock;
  logic [7:0] p1_addr;
  logic [7:0] p1_wdata;
  logic       p1_gnt;
  logic       p1_rvalid;
  logic [7:0] p1_rdata;

  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_dat_in;
  logic [7:0] mem_dat_out;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wr_en, mem_dat_in,
    input  mem_dat_out
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wr_en, mem_dat_in,
    output mem_dat_out
  );
endinterface

// File: rtl/dat_mem_arb.sv
// Two-port round-robin arbiter in front of a 256x8 data memory; port 1 may lock
// for bursts of up to MAX_LOCK grants. Read data is registered one cycle after grant.
module dat_mem_arb #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dat_mem_arb_if.slave   bus
);
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_st_e;

  lock_st_e      st_q, st_d;
  logic          fav_q, fav_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          g0, g1, burst_hold;
  logic          rvalid0_q, rvalid1_q;
  logic [7:0]    rdata0_q, rdata1_q;

  always_comb begin
    burst_hold = (st_q == ST_LOCKED) && bus.p1_req && (cnt_q < MAX_C);
    g0 = 1'b0;
    g1 = 1'b0;
    if (burst_hold) begin
      g1 = 1'b1;
    end else if (bus.p0_req && bus.p1_req) begin
      g0 = ~fav_q;
      g1 = fav_q;
    end else begin
      g0 = bus.p0_req;
      g1 = bus.p1_req;
    end
  end

  // cnt_q is zero whenever the state is open, so cnt_inc is 1 on the locking grant.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    st_d    = ST_OPEN;
    cnt_d   = '0;
    fav_d   = fav_q;
    if (g1) begin
      fav_d = 1'b0;
      if (bus.p1_lock && (cnt_inc < MAX_C)) begin
        st_d  = ST_LOCKED;
        cnt_d = cnt_inc;
      end
    end else if (g0) begin
      fav_d = 1'b1;
    end
  end

  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_dat_in = '0;
    bus.mem_wr_en  = 1'b0;
    if (g0) begin
      bus.mem_addr   = bus.p0_addr;
      bus.mem_dat_in = bus.p0_wdata;
      bus.mem_wr_en  = bus.p0_we & rst_n;
    end else if (g1) begin
      bus.mem_addr   = bus.p1_addr;
      bus.mem_dat_in = bus.p1_wdata;
      bus.mem_wr_en  = bus.p1_we & rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_OPEN;
      fav_q     <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      st_q      <= st_d;
      fav_q     <= fav_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= g0 & ~bus.p0_we;
      rvalid1_q <= g1 & ~bus.p1_we;
      if (g0 && !bus.p0_we) rdata0_q <= bus.mem_dat_out;
      if (g1 && !bus.p1_we) rdata1_q <= bus.mem_dat_out;
    end
  end

  assign bus.p0_gnt    = g0;
  assign bus.p1_gnt    = g1;
  assign bus.p0_rvalid = rvalid0_q;
  assign bus.p1_rvalid = rvalid1_q;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;
endmodule

// File: tb/tb_dat_mem_arb.sv
// Scoreboard bench for dat_mem_arb: a behavioural arbiter/memory model predicts grants,
// memory strobes and queued read responses, which are checked as the DUT produces them.
module tb_dat_mem_arb;
  localparam int unsigned MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dat_mem_arb_if bus ();

  dat_mem_arb #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory behind the arbiter; preloaded through the clocked path.
  logic [7:0] mem [256];
  logic       pre_en;
  logic [7:0] pre_a, pre_d;
  assign bus.mem_dat_out = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_in;
  end

  // Reference model state
  logic [7:0]  mref [256];
  logic        m_fav, m_locked;
  int unsigned m_cnt;
  logic [7:0]  q0[$], q1[$];
  logic [7:0]  last0, last1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fav = 1'b0; m_locked = 1'b0; m_cnt = 0;
    q0.delete(); q1.delete();
    last0 = 8'h00; last1 = 8'h00;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic lk, input logic [7:0] a1,
                       input logic [7:0] d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_lock = lk; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  // Called just after a negedge with inputs driven; returns just after the next negedge.
  task automatic tick();
    logic e0, e1, ew;
    logic [7:0] ea, ed;
    logic r0, w0, r1, w1, lk;
    logic [7:0] a0, d0, a1, d1;
    int unsigned n;
    #1;
    r0 = bus.p0_req; w0 = bus.p0_we; a0 = bus.p0_addr; d0 = bus.p0_wdata;
    r1 = bus.p1_req; w1 = bus.p1_we; a1 = bus.p1_addr; d1 = bus.p1_wdata; lk = bus.p1_lock;
    e1 = r1 && ((m_locked && m_cnt < MAX_LOCK) || !r0 || m_fav);
    e0 = r0 && !e1;
    ea = e0 ? a0 : (e1 ? a1 : 8'h00);
    ed = e0 ? d0 : (e1 ? d1 : 8'h00);
    ew = e0 ? w0 : (e1 ? w1 : 1'b0);
    chk("p0_gnt", {7'b0, bus.p0_gnt}, {7'b0, e0});
    chk("p1_gnt", {7'b0, bus.p1_gnt}, {7'b0, e1});
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_dat_in", bus.mem_dat_in, ed);
    chk("mem_wr_en", {7'b0, bus.mem_wr_en}, {7'b0, ew});
    @(posedge clk);
    if (e0 && !w0) q0.push_back(mref[a0]);
    if (e1 && !w1) q1.push_back(mref[a1]);
    if (ew) mref[ea] = ed;
    if (e1) begin
      n = m_locked ? m_cnt + 1 : 1;
      m_fav = 1'b0;
      if (lk && n < MAX_LOCK) begin m_locked = 1'b1; m_cnt = n; end
      else begin m_locked = 1'b0; m_cnt = 0; end
    end else begin
      if (e0) m_fav = 1'b1;
      m_locked = 1'b0; m_cnt = 0;
    end
    #1;
    chk("p0_rvalid", {7'b0, bus.p0_rvalid}, {7'b0, q0.size() != 0});
    if (q0.size() != 0) last0 = q0.pop_front();
    chk("p0_rdata", bus.p0_rdata, last0);
    chk("p1_rvalid", {7'b0, bus.p1_rvalid}, {7'b0, q1.size() != 0});
    if (q1.size() != 0) last1 = q1.pop_front();
    chk("p1_rdata", bus.p1_rdata, last1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    drive(1'b1, 1'b1, 8'h20, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    chk("rst_p0_rvalid", {7'b0, bus.p0_rvalid}, 8'h00);
    chk("rst_p1_rvalid", {7'b0, bus.p1_rvalid}, 8'h00);
    chk("rst_p0_rdata", bus.p0_rdata, 8'h00);
    chk("rst_p1_rdata", bus.p1_rdata, 8'h00);
    chk("rst_wr_en", {7'b0, bus.mem_wr_en}, 8'h00);
    chk("rst_gnt_comb", {7'b0, bus.p0_gnt}, 8'h01);

    // Preload: 0x00..0x03 = 0x11..0x44, rest random.
    @(negedge clk);
    pre_en = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      pre_a = 8'(i);
      pre_d = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255));
      mref[i] = pre_d;
      @(negedge clk);
    end
    pre_en = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Both request continuously, no lock: alternation starting with port 0.
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 8'(8'h80 + i), 8'h00);
      #1 chk("alt_p0", {7'b0, bus.p0_gnt}, {7'b0, (i % 2) == 0});
      tick();
    end

    // Port 1 writes, port 0 reads the same address next cycle.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
    tick();
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("wr_rd_data", last0, 8'hA5);

    // Back-to-back port 0 reads of preloaded data.
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      chk("b2b_data", last0, 8'(8'h11 * (i + 1)));
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Locked burst: p1 alone starts the lock, then p0 joins; 4 p1 grants, p0, relock.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
    tick();
    for (int unsigned i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 8'h00);
      #1 chk("burst_p1", {7'b0, bus.p1_gnt}, {7'b0, i != 3});
      tick();
    end

    // Random traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      tick();
    end

    // Reset during a locked read burst with a response pending.
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    tick();
    @(posedge clk);
    #1;
    chk("pend_p1_rvalid", {7'b0, bus.p1_rvalid}, 8'h01);
    drive(1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_p1_rvalid", {7'b0, bus.p1_rvalid}, 8'h00);
    chk("mid_rst_p0_rvalid", {7'b0, bus.p0_rvalid}, 8'h00);
    chk("mid_rst_p1_rdata", bus.p1_rdata, 8'h00);
    chk("mid_rst_wr_en", {7'b0, bus.mem_wr_en}, 8'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
    #1 chk("post_rst_p0_wins", {7'b0, bus.p0_gnt}, 8'h01);
    tick();
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/dat_mem_arb.md
DAT_MEM_ARB -- requirements
Module: dat_mem_arb

Interface
REQ-001 Parameter MAX_LOCK, default 4, is the maximum consecutive locked grants to port 1 before port 0 is served.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 Port p0_req  input  1  is the port 0 (processor) access request.
REQ-005 Port p0_we  input  1  is the port 0 write when 1, read when 0.
REQ-006 Port p0_addr  input  8  is the port 0 byte address.
REQ-007 Port p0_wdata  input  8  is the port 0 write data.
REQ-008 Port p0_gnt  output  1  indicates the port 0 access is accepted this cycle.
REQ-009 Port p0_rvalid  output  1  indicates p0_rdata holds the data of the port 0 read granted in the previous cycle.
REQ-010 Port p0_rdata  output  8  is the port 0 read data.
REQ-011 Ports p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata have the same directions, widths and meanings as REQ-004..REQ-010 for port 1 (loader/DMA).
REQ-012 Port p1_lock  input  1  is the port 1 request to keep its grant across consecutive cycles (burst).
REQ-013 Port mem_addr  output  8  is the address to the 256x8 data memory.
REQ-014 Port mem_wr_en  output  1  is the data memory write enable.
REQ-015 Port mem_dat_in  output  8  is the data memory write data.
REQ-016 Port mem_dat_out  input  8  is the data memory combinational read data.

Function
REQ-017 At most one of p0_gnt and p1_gnt SHALL be 1 in any cycle; a grant is only given to a requesting port.
REQ-018 Grant SHALL be combinational from the req inputs and the state registers fav, locked and lock_cnt.
REQ-019 Granted port's addr/wdata SHALL drive mem_addr/mem_dat_in; mem_wr_en = granted port's we; with no grant mem_addr=0, mem_dat_in=0, mem_wr_en=0.
REQ-020 Single requester SHALL be granted immediately, regardless of fav, except per REQ-023.
REQ-021 Both requesting, not locked: grant port indicated by fav (0 = port 0, 1 = port 1).
REQ-022 After each grant to port k, fav SHALL become the other port (round robin); cycles without grant leave fav unchanged.
REQ-023 Locked with p1_req=1 and lock_cnt < MAX_LOCK: port 1 SHALL be granted even if p0_req=1.
REQ-024 locked SHALL set when port 1 is granted with p1_lock=1, and clear when p1_req=0, p1_lock=0, or lock_cnt reaches MAX_LOCK.
REQ-025 lock_cnt SHALL count port 1 grants while locked or locking (1 on the locking grant), reset to 0 when locked clears.
REQ-026 When lock ends by lock_cnt = MAX_LOCK, fav SHALL be 0, so a pending p0_req wins the next cycle; locked may re-set only on a later port 1 grant.
REQ-027 Granted read on port k: pk_rdata SHALL capture mem_dat_out at the granting edge and pk_rvalid SHALL be 1 for exactly the next cycle.
REQ-028 pk_rdata SHALL hold its value when pk_rvalid=0; writes produce no rvalid.
REQ-029 Back-to-back reads SHALL give rvalid in consecutive cycles with no bubble.
REQ-030 Same-cycle write/read conflict is impossible by REQ-017; read of an address written in the prior cycle returns the new data.

Reset
REQ-031 rst_n=0 SHALL immediately force fav=0, locked=0, lock_cnt=0, p0_rvalid=0, p1_rvalid=0, p0_rdata=0, p1_rdata=0.
REQ-032 Grant and mem outputs SHALL remain combinational during reset but mem_wr_en SHALL be 0 while rst_n=0.
REQ-033 Reset asserted mid-burst or with a read pending SHALL drop the lock and the pending rvalid; no response emerges after reset release.

Verification
REQ-034 Both req continuous, no lock, from reset -> grants alternate p0,p1,p0,p1.
REQ-035 p1 writes 0xA5 to 0x10, next cycle p0 reads 0x10 -> p0_rvalid one cycle later, p0_rdata=0xA5.
REQ-036 p1_lock=1, p1_req and p0_req held, MAX_LOCK=4 -> p1 granted 4 cycles, then p0 one cycle, then p1 relocks.
REQ-037 p0 reads 0x00..0x03 back-to-back, memory preloaded with 0x11..0x44 -> p0_rvalid high 4 consecutive cycles, data 0x11,0x22,0x33,0x44.
REQ-038 rst_n low during locked burst with read pending -> rvalid, locked, lock_cnt cleared asynchronously; first post-reset contention grants p0.
